maxpool_seq: RTL and testbench

- Sequencer and output stage for the `maxpool` running-max accumulator.
- Accepts a window-ordered stream of conv results: all POOL_K*POOL_K samples of window 0, then window 1, and so on.
- Drives the accumulator's `i_clean`/`i_read_clean` strobes and gates its input.
- Registers each window maximum behind a valid/ready handshake and signals end of feature map.

---
 rtl/maxpool_seq_pkg.sv | 9 +
 rtl/maxpool.sv | 17 +
 rtl/maxpool_seq.sv | 85 ++++++++
 tb/tb_maxpool_seq.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/maxpool_seq_pkg.sv
// maxpool_seq_pkg: shared data width, most-negative sample and signed max helper
package maxpool_seq_pkg;
    localparam int DW = 16;
    localparam logic signed [DW-1:0] MIN_VAL = {1'b1, {(DW-1){1'b0}}};

    function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/maxpool.sv
// maxpool: running signed max accumulator; clean loads the sample, clean with read_clean zeroes it
module maxpool
    import maxpool_seq_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_clean,
    input  logic                 i_read_clean,
    input  logic signed [DW-1:0] i_data,
    output logic signed [DW-1:0] o_data
);
    // accumulate the maximum, or restart it on a clean strobe
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) o_data <= '0;
        else if (i_clean) o_data <= i_read_clean ? '0 : i_data;
        else o_data <= smax(o_data, i_data);
endmodule

// File: rtl/maxpool_seq.sv
// maxpool_seq: feeds a window-ordered stream through maxpool and hands out each window maximum
module maxpool_seq
    import maxpool_seq_pkg::*;
#(
    parameter int POOL_K = 2,
    parameter int MAP_W  = 24,
    parameter int MAP_H  = 24
)(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic signed [DW-1:0] i_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic signed [DW-1:0] o_data,
    output logic                 o_busy,
    output logic                 o_done
);
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
    localparam int KK    = POOL_K * POOL_K;
    localparam int N_WIN = (MAP_W / POOL_K) * (MAP_H / POOL_K);
    localparam int SW    = $clog2(KK);
    localparam int WW    = $clog2(N_WIN + 1);
    localparam logic [SW-1:0] S_LAST = SW'(KK - 1);
    localparam logic [WW-1:0] W_LAST = WW'(N_WIN - 1);

    state_t state;
    logic [SW-1:0] s;
    logic [WW-1:0] w;
    logic pend, start, accept, xfer, clean;
    logic signed [DW-1:0] acc_in, acc;

    assign start   = (state == IDLE) && i_start;
    assign xfer    = pend && (!o_valid || i_ready);
    // a pending final window already completes the map, so intake closes behind it
    assign o_ready = (state == ACC) && (!pend || xfer) && !(pend && w == W_LAST);
    assign accept  = i_valid && o_ready;
    // the first sample of a window is loaded outright so all-negative windows come out right
    assign clean   = start || (accept && s == '0);
    // idle cycles push the most-negative value so the running max never moves
    assign acc_in  = accept ? i_data : MIN_VAL;
    assign o_busy  = (state == ACC);
    assign o_done  = (state == DONE);

    maxpool u_acc (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clean     (clean),
        .i_read_clean(start),
        .i_data      (acc_in),
        .o_data      (acc)
    );

    // sequencer state, sample/window counters and the output handshake register
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            state   <= IDLE;
            s       <= '0;
            w       <= '0;
            pend    <= 1'b0;
            o_valid <= 1'b0;
            o_data  <= '0;
        end else begin
            o_valid <= xfer || (o_valid && !i_ready);
            pend    <= (accept && s == S_LAST) || (pend && !xfer);
            if (xfer) begin
                o_data <= acc;
                w      <= w + 1'b1;
            end
            case (state)
                IDLE: if (i_start) begin
                    s     <= '0;
                    w     <= '0;
                    state <= ACC;
                end
                ACC: begin
                    if (accept) s <= (s == S_LAST) ? '0 : s + 1'b1;
                    if (xfer && w == W_LAST) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_maxpool_seq.sv
// tb_maxpool_seq: randomized self-checking bench for maxpool_seq against a window-max model
module tb_maxpool_seq;
    import maxpool_seq_pkg::*;
    localparam int K = 2, MW = 4, MH = 4, KK = K * K, NW = (MW / K) * (MH / K), NS = NW * KK;

    logic clk = 1'b0;
    logic rst, i_start, i_valid, o_ready, i_ready, o_valid, o_busy, o_done;
    logic signed [DW-1:0] i_data, o_data;
    int n_chk = 0, n_fail = 0, done_cnt = 0;
    logic signed [DW-1:0] smp [NS];
    logic signed [DW-1:0] exp_q [$];

    always #5 clk = ~clk;

    always @(negedge clk) if (o_done) done_cnt <= done_cnt + 1;

    maxpool_seq #(.POOL_K(K), .MAP_W(MW), .MAP_H(MH)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_valid(i_valid), .o_ready(o_ready),
        .i_data(i_data), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
        .o_busy(o_busy), .o_done(o_done)
    );

    function automatic void build_exp();
        logic signed [DW-1:0] m;
        exp_q.delete();
        for (int wi = 0; wi < NW; wi++) begin
            m = smp[wi * KK];
            for (int j = 1; j < KK; j++) if (smp[wi * KK + j] > m) m = smp[wi * KK + j];
            exp_q.push_back(m);
        end
    endfunction

    task automatic fill_rand(input bit neg);
        for (int i = 0; i < NS; i++) smp[i] = neg ? DW'(-int'($urandom_range(1, 30000))) : DW'($urandom);
    endtask

    task automatic set_win(input int wi, input int a, input int b, input int c, input int d);
        smp[wi * KK]     = DW'(a);
        smp[wi * KK + 1] = DW'(b);
        smp[wi * KK + 2] = DW'(c);
        smp[wi * KK + 3] = DW'(d);
    endtask

    task automatic run_map(input int vpct, input int stall, input int rpct, input int stop_at, input int spulse, input bit chk_lat);
        int idx = 0, ngot = 0, d0, acc_first = -1, acc_last = 0;
        int wc [$];
        bit tmo = 1'b1;
        build_exp();
        d0 = done_cnt;
        @(negedge clk);
        i_start = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(negedge clk);
        for (int cyc = 0; cyc < 600; cyc++) begin
            i_start = (cyc == spulse);
            i_valid = (idx < NS) && (idx < stop_at) && ($urandom_range(0, 99) < vpct);
            if (i_valid) i_data = smp[idx];
            else i_data = DW'($urandom);
            i_ready = (cyc >= stall) && ($urandom_range(0, 99) < rpct);
            #1;
            if (cyc == 0) begin
                n_chk++;
                if (o_busy !== 1'b1) begin n_fail++; $display("FAIL busy: got %b want 1", o_busy); end
            end
            if (o_valid) begin
                n_chk++;
                if (ngot >= NW) begin n_fail++; $display("FAIL extra_out: got %0d want none", o_data); end
                else if (o_data !== exp_q[ngot]) begin n_fail++; $display("FAIL data[%0d]: got %0d want %0d", ngot, o_data, exp_q[ngot]); end
            end
            if (idx / KK - ngot >= 2 && !i_ready) begin
                n_chk++;
                if (o_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready: got %b want 0", o_ready); end
            end
            if (o_done) begin
                n_chk++;
                if (ngot != NW - 1 || o_valid !== 1'b1) begin n_fail++; $display("FAIL done_order: got taken=%0d valid=%b want %0d 1", ngot, o_valid, NW - 1); end
            end
            if (o_valid && i_ready) begin
                if (chk_lat && ngot < wc.size()) begin
                    n_chk++;
                    if (cyc != wc[ngot] + 2) begin n_fail++; $display("FAIL latency[%0d]: got cycle %0d want %0d", ngot, cyc, wc[ngot] + 2); end
                end
                ngot++;
            end
            if (i_valid && o_ready) begin
                if (acc_first < 0) acc_first = cyc;
                acc_last = cyc;
                idx++;
                if (idx % KK == 0) wc.push_back(cyc);
            end
            @(negedge clk);
            if (ngot == NW || idx == stop_at) begin tmo = 1'b0; break; end
        end
        n_chk++;
        if (tmo) begin n_fail++; $display("FAIL timeout: got taken=%0d accepted=%0d want %0d %0d", ngot, idx, NW, NS); end
        if (stop_at >= NS) begin
            i_valid = 1'b0;
            i_ready = 1'b1;
            repeat (3) @(negedge clk);
            n_chk++;
            if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL done_count: got %0d want 1", done_cnt - d0); end
            if (chk_lat) begin
                n_chk++;
                if (acc_last - acc_first != NS - 1) begin n_fail++; $display("FAIL throughput: got %0d cycles want %0d", acc_last - acc_first + 1, NS); end
            end
        end
    endtask

    task automatic check_zero(input string tag);
        n_chk++;
        if ({o_valid, o_ready, o_busy, o_done} !== 4'b0 || o_data !== '0) begin
            n_fail++;
            $display("FAIL %s: got v=%b r=%b b=%b d=%b data=%0d want all 0", tag, o_valid, o_ready, o_busy, o_done, o_data);
        end
    endtask

    task automatic test_reset();
        #2 check_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1 check_zero("idle_after_reset");
    endtask

    task automatic test_back_to_back();
        set_win(0, 3, -5, 7, 1);
        set_win(1, 0, 0, 0, 0);
        set_win(2, 2, 9, 9, 4);
        set_win(3, -1, 6, 5, 5);
        run_map(100, 0, 100, NS, -1, 1'b1);
    endtask

    task automatic test_negative();
        fill_rand(1'b1);
        set_win(0, -4, -9, -2, -8);
        run_map(100, 0, 100, NS, -1, 1'b1);
    endtask

    task automatic test_gaps();
        fill_rand(1'b0);
        set_win(0, 1, 8, 3, 2);
        run_map(40, 0, 100, NS, -1, 1'b0);
    endtask

    task automatic test_backpressure();
        fill_rand(1'b0);
        run_map(100, 10, 100, NS, -1, 1'b0);
    endtask

    task automatic test_reset_mid();
        fill_rand(1'b0);
        run_map(100, 1000, 0, KK + 2, -1, 1'b0);
        rst = 1'b1;
        #1 check_zero("reset_mid");
        @(negedge clk);
        rst = 1'b0;
        fill_rand(1'b1);
        run_map(100, 0, 100, NS, -1, 1'b1);
    endtask

    task automatic test_ignored();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            i_valid = 1'b1;
            i_data = DW'($urandom);
            #1;
            n_chk++;
            if (o_ready !== 1'b0 || o_busy !== 1'b0) begin n_fail++; $display("FAIL idle_ignore: got r=%b b=%b want 0 0", o_ready, o_busy); end
        end
        fill_rand(1'b0);
        run_map(80, 0, 100, NS, 3, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) begin
            fill_rand(i[0]);
            run_map(60, $urandom_range(0, 8), 60, NS, -1, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1;
        i_start = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_data = '0;
        test_reset();
        test_back_to_back();
        test_negative();
        test_gaps();
        test_backpressure();
        test_reset_mid();
        test_ignored();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
